nibble_serial_adder_ctrl: RTL

Multi-precision adder/subtractor sequencer that time-shares one 4-bit adder slice across `WORDS` nibbles of two operands. It processes one nibble per clock, least significant first, and chains the carry through a register between cycles. A start/busy/done handshake lets an upstream controller issue 4·`WORDS`-bit add or subtract operations without instantiating a full-width ripple adder.

---
 rtl/nibble_serial_adder_ctrl_if.sv | 27 ++
 rtl/nibble_serial_adder_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Start/busy/done bus between an upstream controller and the nibble-serial adder.
// Master drives the request (start, op_sub, operands); slave returns result and status.
interface nibble_serial_adder_ctrl_if #(
  parameter int WORDS = 4
);
  localparam int N = 4 * WORDS;

  logic         start;
  logic         op_sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] result;
  logic         c_out;
  logic         overflow;
  logic         busy;
  logic         done;

  modport master (
    output start, op_sub, a, b,
    input  result, c_out, overflow, busy, done
  );

  modport slave (
    input  start, op_sub, a, b,
    output result, c_out, overflow, busy, done
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision add/sub on one 4-bit slice, LSB nibble first; done WORDS cycles after start.
// No backpressure: start is accepted only in IDLE/DONE and silently ignored while busy.
module nibble_serial_adder_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nibble_serial_adder_ctrl_if.slave  bus
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic [WORDS-1:0][3:0]   a_q, a_d;
  logic [WORDS-1:0][3:0]   b_q, b_d;
  logic [WORDS-1:0][3:0]   result_q, result_d;
  logic                    c_out_q, c_out_d;
  logic                    overflow_q, overflow_d;
  logic [4:0]              slice_sum;

  // b is stored already inverted for subtraction so the slice only ever adds.
  assign slice_sum = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + 5'(carry_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;

    case (state_q)
      RUN: begin
        result_d[idx_q] = slice_sum[3:0];
        carry_d         = slice_sum[4];
        if (idx_q == IW'(WORDS - 1)) begin
          c_out_d    = slice_sum[4];
          overflow_d = (a_q[WORDS-1][3] == b_q[WORDS-1][3]) &&
                       (slice_sum[3] != a_q[WORDS-1][3]);
          state_d    = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        // IDLE and DONE accept a new request identically.
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.op_sub ? ~bus.b : bus.b;
          carry_d = bus.op_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
endmodule
